alu_op_sequencer: RTL and testbench

Multi-cycle sequencer in front of the team's 4-bit ALU datapath (add/subtract, shift-add multiply, restoring divide). It accepts one operation at a time over a valid/ready request channel and iterates the shared adder for MUL and DIV. It returns an 8-bit result plus an error flag over a valid/ready response channel. It is the block that turns the combinational ALU pieces into a schedulable, back-pressurable unit.

---
 rtl/alu_op_sequencer_if.sv | 24 ++
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response channel bundle for alu_op_sequencer.
// master: the client issuing ops and consuming results.
// slave : the sequencer itself.
interface alu_op_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle front end for the 4-bit ALU.
// ADD/SUB take one EXEC step, MUL (shift-add) and DIV (restoring) take four.
// Optional divider: define ALU_SEQ_DIV_EN to build it; otherwise opcode 11
// completes immediately with rsp_err=1 and a zero result.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// EXEC  | iterating the datapath, one step per cycle
// DONE  | first cycle formats the response, then holds rsp_valid until taken
module alu_op_sequencer (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus,
  output logic                busy
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  logic [1:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [7:0] acc;
  logic [1:0] step_q;
  logic       err_q;
  logic       ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_result_q;
  logic       rsp_err_q;
  logic       busy_q;

  logic [7:0] acc_nxt;
  logic [4:0] sum5;
  logic [4:0] diff5;
  logic       last_step;

`ifdef ALU_SEQ_DIV_EN
  logic [1:0] div_k;
  logic [4:0] rem_sh;
`endif

  // ready is masked by rst so it reads low throughout a reset cycle
  assign bus.req_ready  = ready_q & ~rst;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = busy_q;

  assign sum5      = {1'b0, a_q} + {1'b0, b_q};
  assign diff5     = {1'b0, a_q} + {1'b0, ~b_q} + 5'd1;
  assign last_step = (op_q[1] == 1'b0) ? 1'b1 : (step_q == 2'd3);

  // one datapath step for the latched op; acc holds {rem, quotient} for DIV
  always_comb begin
    acc_nxt = acc;
`ifdef ALU_SEQ_DIV_EN
    div_k  = 2'd3 - step_q;
    rem_sh = {acc[7:4], a_q[div_k]};
`endif
    case (op_q)
      OP_ADD: acc_nxt = {3'b000, sum5};
      OP_SUB: acc_nxt = {3'b000, diff5};
      OP_MUL: begin
        if (b_q[step_q]) acc_nxt = acc + ({4'h0, a_q} << step_q);
      end
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        // remainder fits in 4 bits after the conditional subtract
        if (rem_sh >= {1'b0, b_q}) begin
          acc_nxt[7:4]  = rem_sh[3:0] - b_q;
          acc_nxt[div_k] = 1'b1;
        end else begin
          acc_nxt[7:4] = rem_sh[3:0];
        end
`else
        acc_nxt = acc;
`endif
      end
      default: acc_nxt = acc;
    endcase
  end

  // control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_ADD;
      a_q          <= 4'h0;
      b_q          <= 4'h0;
      acc          <= 8'h00;
      step_q       <= 2'd0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            op_q    <= bus.req_op;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            acc     <= 8'h00;
            step_q  <= 2'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (bus.req_op == OP_DIV) begin
`ifdef ALU_SEQ_DIV_EN
              if (bus.req_b == 4'h0) begin
                acc   <= {bus.req_a, 4'hF};
                err_q <= 1'b1;
                state <= DONE;
              end else begin
                state <= EXEC;
              end
`else
              err_q <= 1'b1;
              state <= DONE;
`endif
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          acc    <= acc_nxt;
          step_q <= step_q + 2'd1;
          if (last_step) state <= DONE;
        end
        DONE: begin
          if (!rsp_valid_q) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= acc;
            rsp_err_q    <= err_q;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus backpressure and
// mid-operation reset sequences. Honours ALU_SEQ_DIV_EN for DIV expectations.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  alu_op_sequencer_if bus();

  alu_op_sequencer dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   n;
    int   lat;
    logic ready_ok;
    n = 0;
    while (!bus.req_ready && n < 30) begin
      tick();
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    tick();
    bus.req_valid = 1'b0;
    check({tag, " busy"}, int'(busy), 1);
    lat      = 0;
    ready_ok = 1'b1;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.req_ready) ready_ok = 1'b0;
      tick();
      lat++;
    end
    if (bus.req_ready) ready_ok = 1'b0;
    check({tag, " latency"}, lat, v.lat);
    check({tag, " ready_low"}, int'(ready_ok), 1);
    check({tag, " result"}, int'(bus.rsp_result), int'(v.res));
    check({tag, " err"}, int'(bus.rsp_err), int'(v.err));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({tag, " valid_drop"}, int'(bus.rsp_valid), 0);
    check({tag, " idle"}, int'(bus.req_ready), 1);
  endtask

  initial begin
    vec_t v;
    int   n;
    logic seen;

    vecs.push_back('{2'b00, 4'd10, 4'd5,  8'h0F, 1'b0, 2});
    vecs.push_back('{2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 2});
    vecs.push_back('{2'b01, 4'd10, 4'd3,  8'h17, 1'b0, 2});
    vecs.push_back('{2'b01, 4'd3,  4'd5,  8'h0E, 1'b0, 2});
    vecs.push_back('{2'b01, 4'd7,  4'd7,  8'h10, 1'b0, 2});
    vecs.push_back('{2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 5});
    vecs.push_back('{2'b10, 4'd7,  4'd6,  8'h2A, 1'b0, 5});
    vecs.push_back('{2'b10, 4'd0,  4'd9,  8'h00, 1'b0, 5});
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back('{2'b11, 4'd13, 4'd4,  8'h13, 1'b0, 5});
    vecs.push_back('{2'b11, 4'd9,  4'd0,  8'h9F, 1'b1, 1});
    vecs.push_back('{2'b11, 4'd15, 4'd1,  8'h0F, 1'b0, 5});
    vecs.push_back('{2'b11, 4'd3,  4'd7,  8'h30, 1'b0, 5});
`else
    vecs.push_back('{2'b11, 4'd13, 4'd4,  8'h00, 1'b1, 1});
    vecs.push_back('{2'b11, 4'd9,  4'd0,  8'h00, 1'b1, 1});
`endif

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = 4'h0;
    bus.req_b     = 4'h0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst req_ready", int'(bus.req_ready), 0);
    check("rst rsp_valid", int'(bus.rsp_valid), 0);
    check("rst rsp_result", int'(bus.rsp_result), 0);
    check("rst rsp_err", int'(bus.rsp_err), 0);
    check("rst busy", int'(busy), 0);
    rst = 1'b0;
    #1;
    check("post-rst req_ready", int'(bus.req_ready), 1);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // backpressure: MUL 7*6 held 10 cycles, competing request ignored
    v = '{2'b10, 4'd7, 4'd6, 8'h2A, 1'b0, 5};
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    tick();
    bus.req_op = 2'b00;
    bus.req_a  = 4'd1;
    bus.req_b  = 4'd1;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp latency", n, 5);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp valid c%0d", c), int'(bus.rsp_valid), 1);
      check($sformatf("bp result c%0d", c), int'(bus.rsp_result), 8'h2A);
      check($sformatf("bp ready c%0d", c), int'(bus.req_ready), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp not accepted at handshake", int'(busy), 0);
    check("bp ready after handshake", int'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    check("bp accept next cycle", int'(busy), 1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp2 latency", n, 2);
    check("bp2 result", int'(bus.rsp_result), 8'h02);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // reset during EXEC step 2 of MUL 15*15
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b10;
    bus.req_a     = 4'd15;
    bus.req_b     = 4'd15;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst busy", int'(busy), 0);
    check("midrst valid", int'(bus.rsp_valid), 0);
    check("midrst ready during rst", int'(bus.req_ready), 0);
    rst = 1'b0;
    #1;
    check("midrst ready after", int'(bus.req_ready), 1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      tick();
    end
    check("midrst no rsp", int'(seen), 0);
    run_op('{2'b00, 4'd1, 4'd1, 8'h02, 1'b0, 2}, "post-rst add");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
